branch_outcome_queue: RTL and testbench

//  Sits directly downstream of the 2-bit branch predictor. Holds each prediction issued at fetch in an
//  in-order queue until execute resolves that branch. On resolve it compares prediction vs actual

---
 rtl/branch_outcome_queue.sv | 168 ++++++++++++++++
 tb/tb_branch_outcome_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_outcome_queue.sv
// In-order queue of branch predictions; trains the predictor on resolve and flushes on mispredict.
// Latency: training/mispredict outputs registered, visible the cycle after res_valid; pred_ready is combinational.
// Backpressure: pred_ready low when full or during the one-cycle flush; resolves on empty flag sticky underflow.
module branch_outcome_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_request,
    output logic             upd_result,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [PTR_W:0]   occupancy,
    output logic             underflow,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_miss
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_occ;
    logic             r_upd_request;
    logic             r_upd_result;
    logic             r_mispredict;
    logic             r_underflow;
    logic [CNT_W-1:0] r_stat_total;
    logic [CNT_W-1:0] r_stat_miss;

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_mis;
    logic w_push;
    logic w_ready;

    assign w_run   = (r_state == ST_RUN);
    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == OCC_FULL);
    // A pop is only accepted in RUN with something to pop; the head is compared against the actual outcome.
    assign w_pop   = w_run && res_valid && !w_empty;
    assign w_mis   = w_pop && (r_mem[r_rd_ptr] != res_taken);
    // A push that coincides with a mispredict belongs to the wrong path and is dropped.
    assign w_push  = pred_valid && w_ready && !w_mis;

    // Next-state and ready: FLUSH lasts exactly one cycle, ready depends only on state and occupancy.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_ready     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready = !w_full;
                if (w_mis) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Queue storage, pointers and occupancy; a mispredict empties the queue by aligning rd to wr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (w_mis) begin
            r_rd_ptr <= r_wr_ptr;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= pred_taken;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Registered one-cycle training pulse and mispredict flag for each accepted pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_request <= 1'b0;
            r_upd_result  <= 1'b0;
            r_mispredict  <= 1'b0;
        end else begin
            r_upd_request <= w_pop;
            r_upd_result  <= w_pop && res_taken;
            r_mispredict  <= w_mis;
        end
    end

    // Sticky underflow: a resolve arrived in RUN while nothing was outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_run && res_valid && w_empty) begin
            r_underflow <= 1'b1;
        end
    end

    // Saturating statistics: total resolves and mispredicts, both hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_total <= '0;
            r_stat_miss  <= '0;
        end else begin
            if (w_pop && (r_stat_total != '1)) begin
                r_stat_total <= r_stat_total + CNT_ONE;
            end
            if (w_mis && (r_stat_miss != '1)) begin
                r_stat_miss <= r_stat_miss + CNT_ONE;
            end
        end
    end

    assign pred_ready  = w_ready;
    assign upd_request = r_upd_request;
    assign upd_result  = r_upd_result;
    assign upd_taken   = 1'b1;
    assign mispredict  = r_mispredict;
    assign occupancy   = r_occ;
    assign underflow   = r_underflow;
    assign stat_total  = r_stat_total;
    assign stat_miss   = r_stat_miss;

endmodule

// File: tb/tb_branch_outcome_queue.sv
// Directed bench for branch_outcome_queue with a prediction scoreboard and a 2-bit-stat twin instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every step compares ready, training pulse, mispredict, occupancy, underflow and statistics.
module tb_branch_outcome_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        pred_ready;
    logic        upd_request;
    logic        upd_result;
    logic        upd_taken;
    logic        mispredict;
    logic [2:0]  occupancy;
    logic        underflow;
    logic [15:0] stat_total;
    logic [15:0] stat_miss;

    logic        s_pred_ready;
    logic        s_upd_request;
    logic        s_upd_result;
    logic        s_upd_taken;
    logic        s_mispredict;
    logic [2:0]  s_occupancy;
    logic        s_underflow;
    logic [1:0]  s_stat_total;
    logic [1:0]  s_stat_miss;

    branch_outcome_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_request(upd_request), .upd_result(upd_result), .upd_taken(upd_taken),
        .mispredict(mispredict), .occupancy(occupancy), .underflow(underflow),
        .stat_total(stat_total), .stat_miss(stat_miss)
    );

    branch_outcome_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(s_pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_request(s_upd_request), .upd_result(s_upd_result), .upd_taken(s_upd_taken),
        .mispredict(s_mispredict), .occupancy(s_occupancy), .underflow(s_underflow),
        .stat_total(s_stat_total), .stat_miss(s_stat_miss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench model: outstanding predictions and expected {result, mispredict} per resolve.
    bit       pred_q[$];
    bit [1:0] exp_q[$];
    bit       m_flush;
    bit       m_under;
    int       m_total;
    int       m_miss;
    int       m_total_s;
    int       m_miss_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        pred_q.delete();
        exp_q.delete();
        m_flush   = 1'b0;
        m_under   = 1'b0;
        m_total   = 0;
        m_miss    = 0;
        m_total_s = 0;
        m_miss_s  = 0;
    endtask

    task automatic do_reset();
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_pred_ready", 32'(pred_ready), 32'd1);
        chk("rst_upd_request", 32'(upd_request), 32'd0);
        chk("rst_upd_result", 32'(upd_result), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_stat_total", 32'(stat_total), 32'd0);
        chk("rst_stat_miss", 32'(stat_miss), 32'd0);
        chk("rst_upd_taken", 32'(upd_taken), 32'd1);
        rst = 1'b0;
    endtask

    // One clock of stimulus; the scoreboard is updated as the stimulus is driven and drained after the edge.
    task automatic step(input bit pv, input bit pt, input bit rv, input bit rt);
        bit ready_exp;
        bit mis;
        bit head;
        int occ0;
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        occ0       = pred_q.size();
        ready_exp  = !m_flush && (occ0 != DEPTH);
        chk("pred_ready", 32'(pred_ready), 32'(ready_exp));
        mis = 1'b0;
        if (!m_flush && rv) begin
            if (occ0 != 0) begin
                head = pred_q.pop_front();
                mis  = (head != rt);
                exp_q.push_back({rt, mis});
                m_total++;
                if (mis) m_miss++;
                if (m_total_s < 3) m_total_s++;
                if (mis && m_miss_s < 3) m_miss_s++;
            end else begin
                m_under = 1'b1;
            end
        end
        if (mis) pred_q.delete();
        if (pv && ready_exp && !mis) pred_q.push_back(pt);
        m_flush = mis;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        chk("upd_request", 32'(upd_request), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            bit [1:0] e;
            e = exp_q.pop_front();
            chk("upd_result", 32'(upd_result), 32'(e[1]));
            chk("mispredict", 32'(mispredict), 32'(e[0]));
        end else begin
            chk("idle_upd_result", 32'(upd_result), 32'd0);
            chk("idle_mispredict", 32'(mispredict), 32'd0);
        end
        chk("occupancy", 32'(occupancy), 32'(pred_q.size()));
        chk("underflow", 32'(underflow), 32'(m_under));
        chk("stat_total", 32'(stat_total), 32'(m_total));
        chk("stat_miss", 32'(stat_miss), 32'(m_miss));
        chk("small_stat_total", 32'(s_stat_total), 32'(m_total_s));
        chk("small_stat_miss", 32'(s_stat_miss), 32'(m_miss_s));
        chk("upd_taken", 32'(upd_taken), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        clear_model();
        #1;

        // Reset values, including upd_taken held high during reset.
        do_reset();

        // Fill with T,T,N,T; a fifth push is refused; resolve all correctly in order.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("full_occupancy", 32'(occupancy), 32'd4);
        chk("full_ready", 32'(pred_ready), 32'd0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("drain_stat_total", 32'(stat_total), 32'd4);
        chk("drain_stat_miss", 32'(stat_miss), 32'd0);
        chk("drain_occupancy", 32'(occupancy), 32'd0);

        // Mispredict on the first of T,N,N with a same-cycle push that must be dropped, then one flush cycle.
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("mis_pulse", 32'(mispredict), 32'd1);
        chk("mis_result", 32'(upd_result), 32'd0);
        chk("mis_occupancy", 32'(occupancy), 32'd0);
        chk("mis_stat_miss", 32'(stat_miss), 32'd1);
        chk("flush_ready", 32'(pred_ready), 32'd0);
        step(1, 1, 1, 1);
        chk("after_flush_ready", 32'(pred_ready), 32'd1);
        chk("after_flush_mispredict", 32'(mispredict), 32'd0);

        // Steady push+correct resolve at occupancy 2; pointers wrap several times.
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, (i % 3) == 0, 1, pred_q[0]);
            chk("steady_occupancy", 32'(occupancy), 32'd2);
        end
        step(0, 0, 1, pred_q[0]);
        step(0, 0, 1, pred_q[0]);

        // Resolve on an empty queue: sticky underflow, no training, stats unchanged; reset clears it.
        step(0, 0, 1, 1);
        chk("underflow_set", 32'(underflow), 32'd1);
        step(0, 0, 0, 0);
        chk("underflow_sticky", 32'(underflow), 32'd1);
        do_reset();
        chk("underflow_cleared", 32'(underflow), 32'd0);

        // Five mispredicts: the 2-bit twin saturates at 3 while the wide instance counts to 5.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0);
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        chk("sat_small_miss", 32'(s_stat_miss), 32'd3);
        chk("sat_small_total", 32'(s_stat_total), 32'd3);
        chk("wide_miss", 32'(stat_miss), 32'd5);

        // Reset with three outstanding entries discards them.
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("pre_rst_occupancy", 32'(occupancy), 32'd3);
        do_reset();
        step(0, 0, 1, 1);
        chk("post_rst_no_pop", 32'(upd_request), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
